// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the successive-approximation search controller:
// the controller state encoding and the legal range of the trial width.
// ---------------------------------------------------------------------------
package sar_pkg;

   // Controller is either waiting for a request or walking the bits
   typedef enum logic {
      IDLE  = 1'b0,
      PROBE = 1'b1
   } sar_state_t;

   localparam int WIDTH_MIN     = 2;
   localparam int WIDTH_MAX     = 32;
   localparam int WIDTH_DEFAULT = 8;

endpackage : sar_pkg

// File: rtl/sar_search_if.sv
// ---------------------------------------------------------------------------
// sar_search_if
// Bundles the client request/response signals and the comparator link of
// the search controller.
//   i_start   : client requests a new search
//   i_greater : comparator verdict, target > trial
//   i_less    : comparator verdict, target < trial
//   o_trial   : word presented to the comparator b input
//   o_busy    : search in progress
//   o_done    : one-cycle pulse, o_result is valid
//   o_err     : one-cycle pulse, contradictory verdict aborted the search
//   o_result  : recovered value, held until the next done
// Modport master is the controller side; slave is the client/comparator side.
// ---------------------------------------------------------------------------
interface sar_search_if
   import sar_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) ();

   logic             i_start;
   logic             i_greater;
   logic             i_less;
   logic [WIDTH-1:0] o_trial;
   logic             o_busy;
   logic             o_done;
   logic             o_err;
   logic [WIDTH-1:0] o_result;

   modport master (
      input  i_start,
      input  i_greater,
      input  i_less,
      output o_trial,
      output o_busy,
      output o_done,
      output o_err,
      output o_result
   );

   modport slave (
      output i_start,
      output i_greater,
      output i_less,
      input  o_trial,
      input  o_busy,
      input  o_done,
      input  o_err,
      input  o_result
   );

endinterface : sar_search_if

// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search
// Successive-approximation search controller. Drives a trial word into an
// external magnitude comparator, samples its greater/less verdict each
// cycle and converges on the hidden operand in at most WIDTH probes.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears all state immediately
//   bus : sar_search_if.master (start, greater, less, trial, busy, done,
//         err, result)
// The WIDTH parameter must match the WIDTH of the connected interface.
// ---------------------------------------------------------------------------
module sar_search
   import sar_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   sar_search_if.master bus
);

   localparam int IDXW = $clog2(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_widthCheck
      $error("sar_search: WIDTH out of legal range");
   end

   sar_state_t       r_state;
   logic [WIDTH-1:0] r_trial;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_result;
   logic             r_done;
   logic             r_err;

   sar_state_t       w_stateNext;
   logic [WIDTH-1:0] w_trialNext;
   logic [IDXW-1:0]  w_idxNext;
   logic [WIDTH-1:0] w_resultNext;
   logic             w_doneNext;
   logic             w_errNext;
   logic [WIDTH-1:0] w_probe;

   // Next-state logic. Each probe decides the bit under test (r_idx):
   // a "less" verdict means the trial overshot so that bit is cleared,
   // "greater" means it stays set. The next lower bit is then raised for
   // the following probe. An equal verdict ends the search early, and a
   // contradictory verdict (both high) aborts with trial cleared.
   always_comb begin
      w_stateNext  = r_state;
      w_trialNext  = r_trial;
      w_idxNext    = r_idx;
      w_resultNext = r_result;
      w_doneNext   = 1'b0;
      w_errNext    = 1'b0;
      w_probe      = r_trial;

      case (r_state)
         IDLE: begin
            if (bus.i_start) begin
               w_stateNext           = PROBE;
               w_trialNext           = '0;
               w_trialNext[WIDTH-1]  = 1'b1;
               w_idxNext             = IDXW'(WIDTH - 1);
            end
         end

         PROBE: begin
            if (bus.i_greater && bus.i_less) begin
               w_errNext   = 1'b1;
               w_trialNext = '0;
               w_stateNext = IDLE;
            end else if (!bus.i_greater && !bus.i_less) begin
               w_resultNext = r_trial;
               w_doneNext   = 1'b1;
               w_stateNext  = IDLE;
            end else begin
               if (bus.i_less) begin
                  w_probe[r_idx] = 1'b0;
               end
               if (r_idx == '0) begin
                  w_resultNext = w_probe;
                  w_doneNext   = 1'b1;
                  w_stateNext  = IDLE;
               end else begin
                  w_trialNext                      = w_probe;
                  w_trialNext[r_idx - IDXW'(1)]    = 1'b1;
                  w_idxNext                        = r_idx - IDXW'(1);
               end
            end
         end

         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything at once so an
   // aborted search never produces a done or err pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_trial  <= '0;
         r_idx    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_trial  <= w_trialNext;
         r_idx    <= w_idxNext;
         r_result <= w_resultNext;
         r_done   <= w_doneNext;
         r_err    <= w_errNext;
      end
   end

   assign bus.o_trial  = r_trial;
   assign bus.o_busy   = (r_state == PROBE);
   assign bus.o_done   = r_done;
   assign bus.o_err    = r_err;
   assign bus.o_result = r_result;

endmodule : sar_search

// File: tb/tb_sar_search.sv
// ---------------------------------------------------------------------------
// tb_sar_search
// Directed bench for sar_search at WIDTH=8. A behavioural comparator holds
// a hidden target on its a input and the DUT trial on its b input; its
// verdicts can be overridden to inject a contradictory answer.
// ---------------------------------------------------------------------------
module tb_sar_search;
   import sar_pkg::*;

   localparam int W = 8;

   // Hand-derived trial sequences for the full 8-probe searches
   localparam logic [W-1:0] TARGETS [3] = '{8'hA5, 8'h00, 8'hFF};
   localparam logic [W-1:0] SEQ [3][8] = '{
      '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5},
      '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01},
      '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF}
   };
   // Target 0x3C exits early on an equal verdict at the 6th probe
   localparam logic [W-1:0] SEQ3C [6] = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] target = '0;
   logic forceEn = 1'b0;
   logic forceG  = 1'b0;
   logic forceL  = 1'b0;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   sar_search_if #(.WIDTH(W)) bus ();

   sar_search #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural comparator with fault-injection override
   always_comb begin
      bus.i_greater = forceEn ? forceG : (target > bus.o_trial);
      bus.i_less    = forceEn ? forceL : (target < bus.o_trial);
   end

   task automatic test_reset();
      rst = 1'b1;
      bus.i_start = 1'b0;
      #1;
      assertCount++;
      if (bus.o_trial !== '0 || bus.o_result !== '0 || bus.o_busy !== 1'b0 ||
          bus.o_done !== 1'b0 || bus.o_err !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_state: trial=%h result=%h busy=%b done=%b err=%b, required all 0",
                  bus.o_trial, bus.o_result, bus.o_busy, bus.o_done, bus.o_err);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_search();
      for (int c = 0; c < 3; c++) begin
         target = TARGETS[c];
         bus.i_start = 1'b1;
         @(negedge clk);
         bus.i_start = 1'b0;
         for (int p = 0; p < 8; p++) begin
            assertCount++;
            if (bus.o_trial !== SEQ[c][p] || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
               failCount++;
               $display("[TB] FAIL full_probe t=%h p=%0d: trial=%h busy=%b done=%b, required trial=%h busy=1 done=0",
                        target, p, bus.o_trial, bus.o_busy, bus.o_done, SEQ[c][p]);
            end
            @(negedge clk);
         end
         assertCount++;
         if (bus.o_done !== 1'b1 || bus.o_result !== TARGETS[c] || bus.o_busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_done t=%h: done=%b result=%h busy=%b, required done=1 result=%h busy=0",
                     target, bus.o_done, bus.o_result, bus.o_busy, TARGETS[c]);
         end
         @(negedge clk);
         assertCount++;
         if (bus.o_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL done_pulse t=%h: done=%b, required 0", target, bus.o_done);
         end
      end
   endtask

   task automatic test_error();
      // Previous search left result at 0xFF
      target = 8'hA5;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // Third probe (0xA0) is on the comparator now: make it contradictory
      forceEn = 1'b1;
      forceG  = 1'b1;
      forceL  = 1'b1;
      @(negedge clk);
      assertCount++;
      if (bus.o_err !== 1'b1 || bus.o_done !== 1'b0 || bus.o_trial !== 8'h00 ||
          bus.o_result !== 8'hFF || bus.o_busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL err_abort: err=%b done=%b trial=%h result=%h busy=%b, required err=1 done=0 trial=00 result=ff busy=0",
                  bus.o_err, bus.o_done, bus.o_trial, bus.o_result, bus.o_busy);
      end
      forceEn = 1'b0;
      forceG  = 1'b0;
      forceL  = 1'b0;
      @(negedge clk);
      assertCount++;
      if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL err_pulse: err=%b busy=%b, required err=0 busy=0", bus.o_err, bus.o_busy);
      end
      // Recovery: target equal to first probe finishes after one probe
      target = 8'h80;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      assertCount++;
      if (bus.o_trial !== 8'h80 || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL equal_probe: trial=%h busy=%b done=%b, required trial=80 busy=1 done=0",
                  bus.o_trial, bus.o_busy, bus.o_done);
      end
      @(negedge clk);
      assertCount++;
      if (bus.o_done !== 1'b1 || bus.o_result !== 8'h80 || bus.o_busy !== 1'b0 || bus.o_err !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL equal_done: done=%b result=%h busy=%b err=%b, required done=1 result=80 busy=0 err=0",
                  bus.o_done, bus.o_result, bus.o_busy, bus.o_err);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      target = 8'h80;
      bus.i_start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      // start still high while done is high
      assertCount++;
      if (bus.o_done !== 1'b1 || bus.o_result !== 8'h80 || bus.o_busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL b2b_first: done=%b result=%h busy=%b, required done=1 result=80 busy=0",
                  bus.o_done, bus.o_result, bus.o_busy);
      end
      target = 8'h3C;
      @(negedge clk);
      bus.i_start = 1'b0;
      assertCount++;
      if (bus.o_busy !== 1'b1 || bus.o_trial !== SEQ3C[0] || bus.o_done !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL b2b_restart: busy=%b trial=%h done=%b, required busy=1 trial=80 done=0",
                  bus.o_busy, bus.o_trial, bus.o_done);
      end
      for (int p = 1; p < 6; p++) begin
         @(negedge clk);
         // A start pulse mid-search must be ignored and not queued
         bus.i_start = (p == 1);
         assertCount++;
         if (bus.o_trial !== SEQ3C[p] || bus.o_busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL b2b_probe p=%0d: trial=%h busy=%b, required trial=%h busy=1",
                     p, bus.o_trial, bus.o_busy, SEQ3C[p]);
         end
      end
      bus.i_start = 1'b0;
      @(negedge clk);
      assertCount++;
      if (bus.o_done !== 1'b1 || bus.o_result !== 8'h3C || bus.o_trial !== 8'h3C) begin
         failCount++;
         $display("[TB] FAIL b2b_second: done=%b result=%h trial=%h, required done=1 result=3c trial=3c",
                  bus.o_done, bus.o_result, bus.o_trial);
      end
      @(negedge clk);
      assertCount++;
      if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL no_queue: busy=%b done=%b, required busy=0 done=0", bus.o_busy, bus.o_done);
      end
   endtask

   task automatic test_reset_mid();
      target = 8'hA5;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      assertCount++;
      if (bus.o_trial !== '0 || bus.o_result !== '0 || bus.o_busy !== 1'b0 ||
          bus.o_done !== 1'b0 || bus.o_err !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL async_reset: trial=%h result=%h busy=%b done=%b err=%b, required all 0",
                  bus.o_trial, bus.o_result, bus.o_busy, bus.o_done, bus.o_err);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      assertCount++;
      if (bus.o_done !== 1'b0 || bus.o_err !== 1'b0 || bus.o_busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_no_pulse: done=%b err=%b busy=%b, required 0 0 0",
                  bus.o_done, bus.o_err, bus.o_busy);
      end
      target = 8'h3C;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      for (int p = 0; p < 6; p++) begin
         assertCount++;
         if (bus.o_trial !== SEQ3C[p] || bus.o_busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL post_reset_probe p=%0d: trial=%h busy=%b, required trial=%h busy=1",
                     p, bus.o_trial, bus.o_busy, SEQ3C[p]);
         end
         @(negedge clk);
      end
      assertCount++;
      if (bus.o_done !== 1'b1 || bus.o_result !== 8'h3C) begin
         failCount++;
         $display("[TB] FAIL post_reset_done: done=%b result=%h, required done=1 result=3c",
                  bus.o_done, bus.o_result);
      end
      @(negedge clk);
   endtask

   initial begin
      bus.i_start = 1'b0;
      test_reset();
      test_full_search();
      test_error();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule : tb_sar_search

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller: the initiator side of the magnitude-comparator interface. It drives a trial word into an external WIDTH-bit comparator, samples the comparator's greater/less verdict each cycle, and converges on the hidden operand in at most WIDTH probes. It sits beside the comparator library and serves any client that must recover an unknown value through compare-only access, such as threshold discovery or SAR-style conversion.

## Interface
- WIDTH, 8, width of trial/result; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- start  in  1  request a new search; sampled only in IDLE
- greater  in  1  comparator verdict: target > trial (combinational from trial)
- less  in  1  comparator verdict: target < trial
- trial  out  WIDTH  word presented to comparator b input (registered)
- busy  out  1  high while probing
- done  out  1  one-cycle pulse: search finished, result valid
- err  out  1  one-cycle pulse: greater and less both high; search aborted
- result  out  WIDTH  found value; held until next done

## Operation
- States: IDLE, PROBE.
- IDLE with start=1 at an edge: state←PROBE, trial←1<<(WIDTH-1), idx←WIDTH-1.
- PROBE at each edge, with v = trial:
  - greater=1 and less=1: err←1, trial←0, state←IDLE; result unchanged.
  - greater=0 and less=0 (equal): result←v, done←1, state←IDLE (early exit).
  - less=1: clear bit idx of v. greater=1: keep bit idx.
  - If idx==0: result←v, done←1, state←IDLE. Else trial←v with bit idx-1 set, idx←idx-1.
- start is ignored in PROBE and does not queue.
- On returning to IDLE, trial holds its last probed value, except after err, where it is 0.
- All arithmetic is bitwise set/clear on WIDTH bits. No carries and no overflow; the all-ones and zero targets are reachable.

## Timing
- Reset values: trial=0, result=0, busy=0, done=0, err=0, state=IDLE, idx=0.
- Start sampled at edge E0. Probes are sampled at E1..Ek, with k≤WIDTH (k<WIDTH only on an equal verdict).
- busy is high from E0 to Ek. done or err is high for exactly one cycle, from Ek to Ek+1.
- Result is valid at the same edge as done.
- Back-to-back operation: start may be high in the cycle done is high; it is sampled at Ek+1 and the next search begins without a gap.
- The comparator must settle within one cycle of trial. greater and less are sampled only in PROBE.
- Reset asserted mid-search: outputs return to reset values asynchronously. No done or err is emitted for the aborted search.

## Structure
- Package sar_pkg holds the state enum (IDLE, PROBE) and the WIDTH range constants.
- The RTL is a single module with no sub-module.
- The bench instantiates a behavioural WIDTH-bit magnitude comparator with a hidden target on the a input, trial on the b input, and its greater/less outputs wired back. It also has a fault-injection override on greater/less.

## Test plan
- WIDTH=8, target 0xA5, start -> trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done 8 cycles after start edge; result=0xA5.
- Target 0x80 -> equal at first probe; done 1 cycle after start; result=0x80; busy high for 1 cycle.
- Target 0x00 -> trials 0x80,0x40,…,0x01, all less; done after 8 probes; result=0x00. Target 0xFF -> trials 0x80,0xC0,…,0xFF; result=0xFF.
- Force greater=less=1 on the 3rd probe -> err pulse 3 cycles after start; no done; trial=0; previous result retained; next start works normally.
- Pulse start during PROBE -> ignored. Hold start high through done -> second search starts at the edge after done, with no idle cycle.
- Assert rst asynchronously mid-probe (between edges) -> all outputs 0 immediately; after release, target 0x3C search completes with result=0x3C.
